// File: rtl/count_step_ctrl.sv
// count_step_ctrl
//
// Front-end control stage for the four-bit binary counter's count-enable.
// Both raw pushbuttons are synchronized and debounced. The stage emits a
// one-cycle Step pulse that the counter uses as its increment enable.
// In MANUAL mode there is one Step per debounced BtnStep press. In RUN mode
// Step is paced by an internal prescaler with a period of TICK_DIV clocks.
//
// Build option: define STEP_CTRL_RUN_EN to build the BtnMode path, the
// MANUAL/RUN state machine and the prescaler. When it is not defined, the
// block stays in MANUAL, Running is tied to 0 and BtnMode is ignored.
//
// Parameters:
//   DB_CYCLES  stable cycles needed before a debounced level changes (>= 2)
//   TICK_DIV   Step period in RUN mode, in clocks (>= 2)
//
// Ports:
//   Clk      in   system clock, rising edge
//   Reset    in   asynchronous active-low reset
//   BtnStep  in   raw step pushbutton, asynchronous, active-high
//   BtnMode  in   raw mode pushbutton, asynchronous, active-high
//   Step     out  registered one-cycle count-enable pulse
//   Running  out  registered, 1 while in RUN state

module count_step_ctrl #(
  parameter int DB_CYCLES = 16,
  parameter int TICK_DIV  = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic BtnStep,
  input  logic BtnMode,
  output logic Step,
  output logic Running
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  // Debounce step. A mismatch between s and db must persist until the
  // counter reaches its last value before db follows s. Returns {db, cnt}.
  function automatic logic [CW:0] debounce_next(input logic s,
                                                input logic db,
                                                input logic [CW-1:0] cnt);
    logic [CW:0] res;
    if (s == db) begin
      res = {db, {CW{1'b0}}};
    end else if (cnt == CNT_LAST) begin
      res = {s, {CW{1'b0}}};
    end else begin
      res = {db, cnt + CW'(1)};
    end
    return res;
  endfunction

  // ---------------------------------------------------------------- step path
  logic          step_meta_r;
  logic          step_sync_r;
  logic          step_db_r;
  logic [CW-1:0] step_cnt_r;
  logic          step_db_next_s;
  logic [CW-1:0] step_cnt_next_s;
  logic          step_rise_s;
  logic          step_next_s;
  logic          step_r;

  // Two-flop synchronizer for the raw step button
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      step_meta_r <= 1'b0;
      step_sync_r <= 1'b0;
    end else begin
      step_meta_r <= BtnStep;
      step_sync_r <= step_meta_r;
    end
  end

  // Next debounced level and counter for the step button
  always_comb begin
    {step_db_next_s, step_cnt_next_s} = debounce_next(step_sync_r, step_db_r, step_cnt_r);
  end

  // Debounce state for the step button
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      step_db_r  <= 1'b0;
      step_cnt_r <= {CW{1'b0}};
    end else begin
      step_db_r  <= step_db_next_s;
      step_cnt_r <= step_cnt_next_s;
    end
  end

  // Rise is flagged in the cycle before db goes high, so the registered
  // Step pulse lines up with the edge where db itself becomes 1.
  assign step_rise_s = step_db_next_s & ~step_db_r;

`ifdef STEP_CTRL_RUN_EN
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [0:0] {
    MANUAL = 1'b0,
    RUN    = 1'b1
  } state_t;

  logic          mode_meta_r;
  logic          mode_sync_r;
  logic          mode_db_r;
  logic [CW-1:0] mode_cnt_r;
  logic          mode_db_next_s;
  logic [CW-1:0] mode_cnt_next_s;
  logic          mode_rise_s;
  state_t        state_r;
  state_t        state_next_s;
  logic [PW-1:0] p_r;
  logic [PW-1:0] p_next_s;
  logic          running_r;

  // Two-flop synchronizer for the raw mode button
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mode_meta_r <= 1'b0;
      mode_sync_r <= 1'b0;
    end else begin
      mode_meta_r <= BtnMode;
      mode_sync_r <= mode_meta_r;
    end
  end

  // Next debounced level and counter for the mode button
  always_comb begin
    {mode_db_next_s, mode_cnt_next_s} = debounce_next(mode_sync_r, mode_db_r, mode_cnt_r);
  end

  // Debounce state for the mode button
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      mode_db_r  <= 1'b0;
      mode_cnt_r <= {CW{1'b0}};
    end else begin
      mode_db_r  <= mode_db_next_s;
      mode_cnt_r <= mode_cnt_next_s;
    end
  end

  assign mode_rise_s = mode_db_next_s & ~mode_db_r;

  // Mode FSM, prescaler and Step decision. mode_rise takes priority over
  // step_rise. Any mode change clears the prescaler and suppresses Step,
  // so a partial RUN period never produces a pulse.
  always_comb begin
    state_next_s = state_r;
    p_next_s     = {PW{1'b0}};
    step_next_s  = 1'b0;
    case (state_r)
      MANUAL: begin
        if (mode_rise_s) begin
          state_next_s = RUN;
        end else begin
          step_next_s = step_rise_s;
        end
      end
      RUN: begin
        if (mode_rise_s) begin
          state_next_s = MANUAL;
        end else begin
          if (p_r == P_LAST) begin
            p_next_s = {PW{1'b0}};
          end else begin
            p_next_s = p_r + PW'(1);
          end
          // Registered from the prescaler's next value, so Step is high in
          // the same cycle that p holds TICK_DIV-1.
          step_next_s = (p_next_s == P_LAST);
        end
      end
      default: begin
        state_next_s = MANUAL;
      end
    endcase
  end

  // State, prescaler and Running registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r   <= MANUAL;
      p_r       <= {PW{1'b0}};
      running_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      p_r       <= p_next_s;
      running_r <= (state_next_s == RUN);
    end
  end

  assign Running = running_r;
`else
  logic unused_mode_s;

  // The mode button has no function in this build
  assign unused_mode_s = BtnMode;

  // MANUAL only: one pulse per debounced press
  always_comb begin
    step_next_s = step_rise_s;
  end

  assign Running = 1'b0;
`endif

  // Step output register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      step_r <= 1'b0;
    end else begin
      step_r <= step_next_s;
    end
  end

  assign Step = step_r;

endmodule

// File: tb/tb_count_step_ctrl.sv
// Self-checking bench for count_step_ctrl (DB_CYCLES=4, TICK_DIV=8).
// Expected Step cycles are queued when the stimulus is driven. A monitor
// pops one entry for each Step pulse it observes.
module tb_count_step_ctrl;

  localparam int DB  = 4;
  localparam int DIV = 8;

  logic Clk;
  logic Reset;
  logic BtnStep;
  logic BtnMode;
  logic Step;
  logic Running;

  int cyc       = 0;
  int n_chk     = 0;
  int n_err     = 0;
  int pulse_cnt = 0;
  int exp_q[$];

  count_step_ctrl #(.DB_CYCLES(DB), .TICK_DIV(DIV)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .BtnStep(BtnStep),
    .BtnMode(BtnMode),
    .Step   (Step),
    .Running(Running)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Edge counter: after rising edge n, cyc == n
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Scoreboard monitor: each observed pulse must match the oldest expected cycle
  always @(negedge Clk) begin
    if (Reset === 1'b1 && Step === 1'b1) begin
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        check("step_unexpected", cyc, 0);
      end else begin
        check("step_cycle", cyc, exp_q.pop_front());
      end
    end
  end

  initial begin
    int t;
    int pc0;
    Reset   = 1'b0;
    BtnStep = 1'b0;
    BtnMode = 1'b0;
    cycles(3);
    check("rst_step", Step, 1'b0);
    check("rst_running", Running, 1'b0);
    Reset = 1'b1;
    cycles(5);

    // Clean press: one pulse in the cycle after E0+DB+1
    BtnStep = 1'b1;
    exp_q.push_back(cyc + DB + 2);
    cycles(20);
    check("clean_running", Running, 1'b0);
    BtnStep = 1'b0;
    cycles(12);
    check("clean_drained", exp_q.size(), 0);

    // Glitch of DB-1 cycles is discarded
    BtnStep = 1'b1; cycles(3);
    BtnStep = 1'b0; cycles(12);
    // Bounce: high 2, low 1, high 2, low
    BtnStep = 1'b1; cycles(2);
    BtnStep = 1'b0; cycles(1);
    BtnStep = 1'b1; cycles(2);
    BtnStep = 1'b0; cycles(12);
    // Bounce then stable high: exactly one pulse, counted from the stable part
    BtnStep = 1'b1; cycles(2);
    BtnStep = 1'b0; cycles(1);
    BtnStep = 1'b1;
    exp_q.push_back(cyc + DB + 2);
    cycles(20);
    BtnStep = 1'b0;
    cycles(12);
    check("bounce_drained", exp_q.size(), 0);

`ifdef STEP_CTRL_RUN_EN
    // RUN pacing. Running rises at edge T. Pulses at T+7+8k until leaving
    // RUN at T+51.
    t = cyc + DB + 2;
    BtnMode = 1'b1;
    for (int k = 0; k < 6; k++) exp_q.push_back(t + DIV - 1 + DIV * k);
    cycles(DB + 1);
    check("run_not_yet", Running, 1'b0);
    cycles(1);
    check("run_rise", Running, 1'b1);
    pc0 = pulse_cnt;
    cycles(2);
    BtnMode = 1'b0;
    cycles(8);
    BtnStep = 1'b1;            // ignored in RUN
    cycles(8);
    BtnStep = 1'b0;
    cycles(22);                // now at T+40
    check("run_pulses_40", pulse_cnt - pc0, 5);
    cycles(5);                 // T+45: leave RUN mid-period
    BtnMode = 1'b1;
    cycles(DB + 1);
    check("leave_not_yet", Running, 1'b1);
    cycles(1);
    check("leave_fall", Running, 1'b0);
    cycles(2);
    BtnMode = 1'b0;
    cycles(20);
    check("leave_drained", exp_q.size(), 0);

    // Simultaneous presses from MANUAL: mode wins, no manual Step
    t = cyc;
    BtnStep = 1'b1;
    BtnMode = 1'b1;
    exp_q.push_back(t + DB + 2 + DIV - 1);
    exp_q.push_back(t + DB + 2 + 2 * DIV - 1);
    cycles(DB + 2);
    check("prio_running", Running, 1'b1);
    cycles(2);
    BtnStep = 1'b0;
    BtnMode = 1'b0;
    cycles(12);                // t+20
    BtnMode = 1'b1;
    cycles(DB + 2);
    check("prio_exit", Running, 1'b0);
    cycles(2);
    BtnMode = 1'b0;
    cycles(20);
    check("prio_drained", exp_q.size(), 0);

    // Async reset between edges while Step is high in RUN
    t = cyc + DB + 2;
    BtnMode = 1'b1;
    cycles(8);
    BtnMode = 1'b0;
    cycles(t + DIV - 2 - cyc);
    @(posedge Clk);
    #2;
    check("pre_arst_step", Step, 1'b1);
    check("pre_arst_running", Running, 1'b1);
    Reset = 1'b0;
    #1;
    check("arst_step", Step, 1'b0);
    check("arst_running", Running, 1'b0);
    cycles(2);
`else
    // Mode button has no effect in this build
    BtnMode = 1'b1;
    cycles(15);
    check("nomode_running", Running, 1'b0);
    BtnMode = 1'b0;
    cycles(12);
    // Both pressed together: the step press still yields its pulse
    BtnStep = 1'b1;
    BtnMode = 1'b1;
    exp_q.push_back(cyc + DB + 2);
    cycles(15);
    check("nomode_both_running", Running, 1'b0);
    BtnStep = 1'b0;
    BtnMode = 1'b0;
    cycles(12);
    check("nomode_drained", exp_q.size(), 0);
    Reset = 1'b0;
    cycles(2);
`endif

    // Button held through reset release: debounced afresh, one pulse
    BtnStep = 1'b1;
    cycles(3);
    check("held_rst_step", Step, 1'b0);
    Reset = 1'b1;
    exp_q.push_back(cyc + DB + 2);
    cycles(20);
    check("held_running", Running, 1'b0);
    BtnStep = 1'b0;
    cycles(12);

    check("final_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
